// File: rtl/wheel_drive.sv
`default_nettype none
// ============================================================================
// Module      : wheel_drive
// Description : Two-wheel motor driver. Latches per-wheel stop/forward/reverse
//               commands with a target speed and produces PWM + direction per
//               wheel. Duty is slew-limited, wheels brake to zero before any
//               reversal, and a dead-time window separates direction flips.
// Revision    : 1.0 - initial release
// ============================================================================
module wheel_drive #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_DIV    = 16,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_l,
  input  logic [1:0]          cmd_r,
  input  logic [PWM_BITS-1:0] speed,
  output logic                pwm_l,
  output logic                pwm_r,
  output logic                dir_l,
  output logic                dir_r,
  output logic [1:0]          state_l,
  output logic [1:0]          state_r
);

  localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  // Counter runs 0 .. 2^PWM_BITS-2 so that a full-scale duty is constant high.
  localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(RAMP_DIV - 1);
  // DEAD is held while the counter walks DEAD_CYCLES-1 down to 0 inclusive.
  localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_BRAKE = 2'b10,
    ST_DEAD  = 2'b11
  } wheel_state_e;

  // Shared timing
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick;

  // Latched command
  logic                cmd_accept;
  logic [1:0]          cmd_q [2];
  logic [1:0]          cmd_d [2];
  logic [PWM_BITS-1:0] speed_q, speed_d;

  // Per-wheel state (index 0 = left, 1 = right)
  wheel_state_e        state_q [2];
  wheel_state_e        state_d [2];
  logic [PWM_BITS-1:0] duty_q  [2];
  logic [PWM_BITS-1:0] duty_d  [2];
  logic                dir_q   [2];
  logic                dir_d   [2];
  logic [DEAD_W-1:0]   dead_q  [2];
  logic [DEAD_W-1:0]   dead_d  [2];
  logic                pwm_q   [2];
  logic                pwm_d   [2];
  logic                same_dir [2];
  logic                opp_dir  [2];

  // New commands are refused while either wheel sits in its dead-time window.
  assign cmd_ready  = (state_q[0] != ST_DEAD) && (state_q[1] != ST_DEAD);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign tick       = (pre_q == PRE_LAST);

  // Free-running PWM counter and ramp prescaler.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
  end

  // Capture both wheel commands and the speed together on a handshake.
  always_comb begin
    cmd_d[0] = cmd_q[0];
    cmd_d[1] = cmd_q[1];
    speed_d  = speed_q;
    if (cmd_accept) begin
      cmd_d[0] = cmd_l;
      cmd_d[1] = cmd_r;
      speed_d  = speed;
    end
  end

  // Compare each latched request against the wheel's present direction.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      same_dir[i] = ((cmd_q[i] == 2'b01) &&  dir_q[i]) ||
                    ((cmd_q[i] == 2'b10) && !dir_q[i]);
      opp_dir[i]  = ((cmd_q[i] == 2'b01) && !dir_q[i]) ||
                    ((cmd_q[i] == 2'b10) &&  dir_q[i]);
    end
  end

  // Per-wheel next state: ramp in DRIVE, ramp down in BRAKE, flip after DEAD.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      dir_d[i]   = dir_q[i];
      dead_d[i]  = dead_q[i];
      case (state_q[i])
        ST_STOP: begin
          duty_d[i] = '0;
          if (same_dir[i]) begin
            state_d[i] = ST_DRIVE;
          end else if (opp_dir[i]) begin
            dead_d[i]  = DEAD_LOAD;
            state_d[i] = ST_DEAD;
          end
        end
        ST_DRIVE: begin
          if (!same_dir[i]) begin
            // Stop or reversal: hand over to BRAKE with duty frozen this cycle.
            state_d[i] = ST_BRAKE;
          end else if (tick) begin
            if (duty_q[i] < speed_q) begin
              duty_d[i] = duty_q[i] + 1'b1;
            end else if (duty_q[i] > speed_q) begin
              duty_d[i] = duty_q[i] - 1'b1;
            end
          end
        end
        ST_BRAKE: begin
          if (same_dir[i]) begin
            // Request matches current direction again: resume without dead-time.
            state_d[i] = ST_DRIVE;
          end else if (duty_q[i] == '0) begin
            if (opp_dir[i]) begin
              dead_d[i]  = DEAD_LOAD;
              state_d[i] = ST_DEAD;
            end else begin
              state_d[i] = ST_STOP;
            end
          end else if (tick) begin
            duty_d[i] = duty_q[i] - 1'b1;
          end
        end
        ST_DEAD: begin
          duty_d[i] = '0;
          if (dead_q[i] == '0) begin
            dir_d[i]   = ~dir_q[i];
            state_d[i] = ST_DRIVE;
          end else begin
            dead_d[i] = dead_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_STOP;
          duty_d[i]  = '0;
        end
      endcase
    end
  end

  // PWM compare; only DRIVE and BRAKE may ever drive the motor.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pwm_d[i] = ((state_q[i] == ST_DRIVE) || (state_q[i] == ST_BRAKE)) &&
                 (cnt_q < duty_q[i]);
    end
  end

  // State registers with immediate (asynchronous) reset to a safe stop.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      pre_q   <= '0;
      speed_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cmd_q[i]   <= 2'b00;
        state_q[i] <= ST_STOP;
        duty_q[i]  <= '0;
        dir_q[i]   <= 1'b1;
        dead_q[i]  <= '0;
        pwm_q[i]   <= 1'b0;
      end
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      speed_q <= speed_d;
      for (int i = 0; i < 2; i++) begin
        cmd_q[i]   <= cmd_d[i];
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
        dir_q[i]   <= dir_d[i];
        dead_q[i]  <= dead_d[i];
        pwm_q[i]   <= pwm_d[i];
      end
    end
  end

  assign pwm_l   = pwm_q[0];
  assign pwm_r   = pwm_q[1];
  assign dir_l   = dir_q[0];
  assign dir_r   = dir_q[1];
  assign state_l = state_q[0];
  assign state_r = state_q[1];

endmodule
`default_nettype wire

// File: tb/tb_wheel_drive.sv
`default_nettype none
// ============================================================================
// Module      : tb_wheel_drive
// Description : Self-checking bench for wheel_drive. A cycle-level behavioural
//               model predicts every output; directed scenarios plus random
//               command streams and random asynchronous resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wheel_drive;

  localparam int PB     = 4;
  localparam int RD     = 2;
  localparam int DC     = 3;
  localparam int PERIOD = (1 << PB) - 1;

  localparam int S_STOP  = 0;
  localparam int S_DRIVE = 1;
  localparam int S_BRAKE = 2;
  localparam int S_DEAD  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_l = 2'b00;
  logic [1:0]    cmd_r = 2'b00;
  logic [PB-1:0] speed = '0;
  logic          cmd_ready, pwm_l, pwm_r, dir_l, dir_r;
  logic [1:0]    state_l, state_r;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Behavioural model: values the DUT registers must hold after each edge.
  int m_state [2];
  int m_duty  [2];
  int m_left  [2];   // dead-time cycles still to spend
  int m_cmd   [2];
  bit m_dir   [2];
  bit m_pwm   [2];
  int m_speed;
  int m_k;           // clock edges since reset release

  wheel_drive #(
    .PWM_BITS   (PB),
    .RAMP_DIV   (RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_l    (cmd_l),
    .cmd_r    (cmd_r),
    .speed    (speed),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .dir_l    (dir_l),
    .dir_r    (dir_r),
    .state_l  (state_l),
    .state_r  (state_r)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit m_ready();
    return (m_state[0] != S_DEAD) && (m_state[1] != S_DEAD);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_STOP;
      m_duty[i]  = 0;
      m_left[i]  = 0;
      m_cmd[i]   = 0;
      m_dir[i]   = 1'b1;
      m_pwm[i]   = 1'b0;
    end
    m_speed = 0;
    m_k     = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit tick, acc, same, opp;
    int cnt, want;
    bit nxt_pwm [2];
    tick = (m_k % RD) == (RD - 1);
    cnt  = m_k % PERIOD;
    acc  = cmd_valid && m_ready();
    for (int i = 0; i < 2; i++) begin
      nxt_pwm[i] = (m_state[i] == S_DRIVE || m_state[i] == S_BRAKE) && (cnt < m_duty[i]);
      want = (m_cmd[i] == 1) ? 1 : ((m_cmd[i] == 2) ? -1 : 0);
      same = (want != 0) && ((want > 0) == m_dir[i]);
      opp  = (want != 0) && !same;
      case (m_state[i])
        S_STOP: begin
          if (same) m_state[i] = S_DRIVE;
          else if (opp) begin
            m_state[i] = S_DEAD;
            m_left[i]  = DC;
          end
        end
        S_DRIVE: begin
          if (!same) m_state[i] = S_BRAKE;
          else if (tick) begin
            if (m_speed > m_duty[i]) m_duty[i] = m_duty[i] + 1;
            else if (m_speed < m_duty[i]) m_duty[i] = m_duty[i] - 1;
          end
        end
        S_BRAKE: begin
          if (same) m_state[i] = S_DRIVE;
          else if (m_duty[i] == 0) begin
            if (opp) begin
              m_state[i] = S_DEAD;
              m_left[i]  = DC;
            end else begin
              m_state[i] = S_STOP;
            end
          end else if (tick) m_duty[i] = m_duty[i] - 1;
        end
        default: begin
          m_duty[i] = 0;
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_dir[i]   = !m_dir[i];
            m_state[i] = S_DRIVE;
          end
        end
      endcase
    end
    if (acc) begin
      m_cmd[0] = cmd_l;
      m_cmd[1] = cmd_r;
      m_speed  = speed;
    end
    m_pwm[0] = nxt_pwm[0];
    m_pwm[1] = nxt_pwm[1];
    m_k++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: all DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      total++;
      if ({cmd_ready, state_l, state_r, dir_l, dir_r, pwm_l, pwm_r} !==
          {m_ready(), 2'(m_state[0]), 2'(m_state[1]), m_dir[0], m_dir[1], m_pwm[0], m_pwm[1]}) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got rdy/sl/sr/dl/dr/pl/pr=%b want=%b", $time,
                 {cmd_ready, state_l, state_r, dir_l, dir_r, pwm_l, pwm_r},
                 {m_ready(), 2'(m_state[0]), 2'(m_state[1]), m_dir[0], m_dir[1], m_pwm[0], m_pwm[1]});
      end
    end
  end

  // One clock with current inputs; returns just after the falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] l, input logic [1:0] r, input int spd);
    cmd_valid = 1'b1;
    cmd_l     = l;
    cmd_r     = r;
    speed     = PB'(spd);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_outputs", {cmd_ready, state_l, state_r, dir_l, dir_r, pwm_l, pwm_r}, 9'b1_00_00_11_00);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic count_pwm(output int nl, output int nr);
    nl = 0;
    nr = 0;
    for (int j = 0; j < PERIOD; j++) begin
      cycle();
      nl += int'(pwm_l);
      nr += int'(pwm_r);
    end
  endtask

  task automatic wait_left(input int want, input int limit, input string name);
    int n;
    n = 0;
    while (state_l != 2'(want) && n < limit) begin
      cycle();
      n++;
    end
    check(name, state_l, want);
  endtask

  initial begin
    int nl, nr, n, nrdy;
    bit saw;

    #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cmp_on = 1'b1;

    // Idle after reset
    repeat (100) cycle();
    check("idle_state_l", state_l, 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_dir", {dir_l, dir_r}, 3);

    // Both forward at speed 6
    send(2'b01, 2'b01, 6);
    cycle();
    check("fwd_state_l", state_l, 1);
    check("fwd_state_r", state_r, 1);
    repeat (20) cycle();
    check("model_duty6", m_duty[0], 6);
    count_pwm(nl, nr);
    check("fwd_pwm_l_6of15", nl, 6);
    check("fwd_pwm_r_6of15", nr, 6);

    // Left reverses: brake, dead-time, flip, ramp back
    send(2'b10, 2'b01, 6);
    cycle();
    check("rev_brake", state_l, 2);
    wait_left(3, 40, "rev_reach_dead");
    n = 0;
    nrdy = 0;
    while (state_l == 2'd3 && n < 10) begin
      if (!cmd_ready) nrdy++;
      n++;
      cycle();
    end
    check("dead_len", n, 3);
    check("dead_ready_low", nrdy, 3);
    check("rev_dir_l", dir_l, 0);
    check("rev_state_l", state_l, 1);
    check("rev_state_r", state_r, 1);
    repeat (20) cycle();
    count_pwm(nl, nr);
    check("rev_pwm_l_6of15", nl, 6);
    check("rev_pwm_r_6of15", nr, 6);

    // Back to forward, then brake to duty 3 and re-request forward
    send(2'b01, 2'b01, 6);
    n = 0;
    while (!(state_l == 2'd1 && dir_l) && n < 60) begin
      cycle();
      n++;
    end
    check("fwd_again_dir", dir_l, 1);
    repeat (20) cycle();
    send(2'b00, 2'b01, 6);
    n = 0;
    while (!(m_state[0] == S_BRAKE && m_duty[0] == 3) && n < 40) begin
      cycle();
      n++;
    end
    check("brake_at3", state_l, 2);
    send(2'b01, 2'b01, 6);
    cycle();
    check("resume_drive", state_l, 1);
    check("resume_dir", dir_l, 1);
    saw = 1'b0;
    repeat (20) begin
      cycle();
      if (state_l == 2'd3) saw = 1'b1;
    end
    check("resume_no_dead", saw, 0);
    count_pwm(nl, nr);
    check("resume_pwm_l_6of15", nl, 6);

    // Full speed, then code 11 acts as stop
    send(2'b01, 2'b01, 15);
    repeat (40) cycle();
    count_pwm(nl, nr);
    check("full_pwm_l", nl, 15);
    check("full_pwm_r", nr, 15);
    send(2'b11, 2'b11, 15);
    cycle();
    check("c11_brake_l", state_l, 2);
    check("c11_brake_r", state_r, 2);
    repeat (40) cycle();
    check("c11_stop_l", state_l, 0);
    check("c11_stop_r", state_r, 0);
    count_pwm(nl, nr);
    check("c11_pwm_off", nl + nr, 0);

    // Reset while left is in DEAD and right drives at duty 9
    send(2'b01, 2'b01, 9);
    repeat (30) cycle();
    send(2'b10, 2'b01, 9);
    wait_left(3, 40, "rst_reach_dead");
    check("rst_right_drive", state_r, 1);
    check("model_duty_r9", m_duty[1], 9);
    do_reset();
    cycle();
    check("post_rst_l", state_l, 0);
    check("post_rst_r", state_r, 0);
    check("post_rst_ready", cmd_ready, 1);

    // Random command streams with occasional asynchronous resets
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset();
      end else begin
        cmd_valid = 1'b1;
        cmd_l     = 2'($urandom_range(0, 3));
        cmd_r     = 2'($urandom_range(0, 3));
        speed     = PB'($urandom_range(0, 15));
        cycle();
        for (int h = $urandom_range(1, 40); h > 0; h--) begin
          // Offer commands only while the handshake must refuse them.
          cmd_valid = !m_ready() && ($urandom_range(0, 1) == 1);
          cmd_l     = 2'($urandom_range(0, 3));
          cmd_r     = 2'($urandom_range(0, 3));
          speed     = PB'($urandom_range(0, 15));
          cycle();
        end
        cmd_valid = 1'b0;
      end
    end

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wheel_drive.md
Name: wheel_drive

Overview:
- Consumes per-wheel motion commands (stop / forward / reverse) plus a target speed, and drives the left and right motor outputs.
- Each motor output is a PWM signal plus a direction line.
- Sits downstream of the robot's sensor and manual-key steering logic, which decides what each wheel should do; this block turns those decisions into safe motor signals.
- Safety comes from speed ramping, braking before reversal, and a dead-time before any direction flip.

Parameters:
- PWM_BITS, 8: width of duty, speed and PWM counter. PWM period = 2^PWM_BITS - 1 cycles.
- RAMP_DIV, 16: cycles between ramp ticks. Duty moves by at most 1 per tick. Must be >= 1.
- DEAD_CYCLES, 8: cycles with PWM forced low before a direction flip. Must be >= 1.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
- cmd_l  in  2  left wheel command: 00 stop, 01 forward, 10 reverse, 11 treated as stop.
- cmd_r  in  2  right wheel command, same encoding.
- speed  in  PWM_BITS  target duty for any wheel commanded forward or reverse.
- pwm_l, pwm_r  out  1  motor PWM.
- dir_l, dir_r  out  1  1 = forward, 0 = reverse.
- state_l, state_r  out  2  wheel FSM state: 00 STOP, 01 DRIVE, 10 BRAKE, 11 DEAD.

Behaviour:
- Reset (async, immediate):
  - pwm_l/pwm_r = 0, dir_l/dir_r = 1, state = STOP for both wheels.
  - Duty registers 0; latched commands = stop; latched speed 0.
  - PWM counter 0; ramp prescaler 0; DEAD counters 0; cmd_ready = 1.
  - Reset asserted mid-ramp or mid-DEAD aborts immediately; no ramp-down.
- Handshake:
  - cmd_ready = 1 unless either wheel is in DEAD (combinational from state).
  - On accept, cmd_l, cmd_r and speed are latched together. FSMs act on the latched values from the next cycle on.
  - Unaccepted inputs are ignored. A repeated identical command is harmless.
- PWM:
  - One shared counter runs 0 .. 2^PWM_BITS-2, then wraps to 0.
  - pwm_x = (counter < duty_x), registered, so one cycle of latency.
  - duty 0 gives constant low; duty 2^PWM_BITS-1 gives constant high.
  - PWM is forced 0 in DEAD and STOP.
- Ramp tick: the prescaler counts 0 .. RAMP_DIV-1; tick is high for the one cycle when prescaler == RAMP_DIV-1.
- Per-wheel FSM (identical for left and right). "Requested direction" = latched command forward (1) or reverse (0).
  - STOP (duty 0):
    - latched stop: stay.
    - request equals dir: go to DRIVE.
    - request opposite to dir: load DEAD counter, go to DEAD.
  - DRIVE:
    - On tick, duty moves 1 toward latched speed. Speed lowered below duty ramps down; speed 0 holds duty 0 while staying in DRIVE.
    - latched stop or opposite direction: go to BRAKE.
  - BRAKE:
    - On tick, duty decrements.
    - Request equal to dir while duty > 0: back to DRIVE, no dead-time.
    - duty == 0 and latched stop: go to STOP.
    - duty == 0 and opposite request: go to DEAD.
  - DEAD:
    - Counter runs DEAD_CYCLES cycles; PWM low; duty 0.
    - On expiry, dir inverts and the wheel enters DRIVE.
    - Commands cannot change during DEAD because cmd_ready is 0.
- Wheels are independent. One wheel may be in DEAD while the other ramps, and both may enter DEAD on the same cycle.
- Duty never exceeds 2^PWM_BITS-1 and never underflows below 0.
- Direction changes only on DEAD expiry. pwm is never high in the cycle dir changes or in the cycle after.

Test Plan (bench overrides: PWM_BITS=4, RAMP_DIV=2, DEAD_CYCLES=3):
- Reset release, no commands -> pwm 0, dir 1, state 00, cmd_ready 1 for 100 cycles.
- Accept cmd_l=01, cmd_r=01, speed=6 -> both states 01. Duty rises by 1 every 2 cycles and reaches 6 after 12 cycles. Then pwm high exactly 6 of every 15 cycles.
- From the previous case, accept cmd_l=10 -> left state 10, duty 6→0 over 12 cycles, then state 11. pwm_l low and cmd_ready 0 for 3 cycles. dir_l flips to 0, then ramps back to duty 6. Right wheel unaffected throughout.
- While left is in BRAKE at duty 3, accept cmd_l=01 -> state 01 immediately, dir_l stays 1, duty climbs 3→6, no DEAD entry.
- Accept speed=15 forward -> pwm constant high once duty reaches 15. Then cmd=11 on both -> treated as stop: BRAKE then STOP, pwm 0.
- Assert reset while left is in DEAD and right is in DRIVE at duty 9 -> all outputs reach reset values before the next clock edge. After release, both wheels are in STOP with cmd_ready 1.
